// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS multiply/divide unit with architectural HI/LO.
// MULT/MULTU use radix-2 shift-add; DIV/DIVU use restoring division.
// Both take one bit per cycle in CALC, with sign correction applied in FIX.
// Optional feature: define MDU_EARLY_OUT_EN to end multiplies as soon as the
// remaining multiplier bits are all zero. Divide timing does not change.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        sel_hi,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div;     // latched op[1]
  logic        neg_res;    // product / quotient must be negated
  logic        neg_rem;    // remainder takes the (negative) dividend sign
  logic        dz;         // divide with a zero divisor
  logic [63:0] acc;        // multiply accumulator
  logic [63:0] mcand;      // multiplicand, shifted left each iteration
  logic [31:0] mplr;       // multiplier, or dividend shifting into quotient
  logic [31:0] dvsr;       // divisor magnitude
  logic [31:0] rem;        // partial remainder
  logic [32:0] rem_shift;  // 33-bit trial partial remainder
  logic [31:0] rem_sub;
  logic        rem_ge;
  logic        signed_op;
  logic [31:0] mag_a, mag_b;
  logic        calc_last;

  // Operand conditioning: signed ops use magnitudes, unsigned ops use raw values.
  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign mag_b     = (signed_op && rt_data[31]) ? (32'd0 - rt_data) : rt_data;

  // Restoring-division step: shift in the next dividend bit, then try to subtract.
  assign rem_shift = {rem, mplr[31]};
  assign rem_ge    = rem_shift >= {1'b0, dvsr};
  assign rem_sub   = 32'(rem_shift - {1'b0, dvsr});

  // Last CALC iteration: either the fixed count or the multiply early-out.
`ifdef MDU_EARLY_OUT_EN
  assign calc_last = (cnt == 5'd31) || (!is_div && (mplr[31:1] == 31'd0));
`else
  assign calc_last = (cnt == 5'd31);
`endif

  assign result = sel_hi ? hi : lo;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: every sequential assignment is non-blocking, so all registers
    // update from values sampled before the edge.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and busy decode.
  always_comb begin
    // NOTE: defaults come first so that no path leaves an output unassigned.
    // An unassigned path would infer a latch.
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (calc_last) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, per-cycle iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mplr        <= '0;
      dvsr        <= '0;
      rem         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // A start in the same cycle as MTHI/MTLO wins, and the write is dropped.
            cnt     <= '0;
            is_div  <= op[1];
            neg_res <= signed_op && (rs_data[31] ^ rt_data[31]);
            neg_rem <= signed_op && rs_data[31];
            dz      <= op[1] && (rt_data == 32'd0);
            acc     <= '0;
            rem     <= '0;
            mcand   <= {32'd0, mag_a};
            dvsr    <= mag_b;
            mplr    <= op[1] ? mag_a : mag_b;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            rem  <= rem_ge ? rem_sub : rem_shift[31:0];
            mplr <= {mplr[30:0], rem_ge};
          end else begin
            if (mplr[0]) acc <= acc + mcand;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
          end
        end
        FIX: begin
          done        <= 1'b1;
          div_by_zero <= dz;
          if (is_div) begin
            // With a zero divisor, the remainder ends up equal to the dividend magnitude.
            // Sign correction of that magnitude gives back the original rs_data.
            lo <= dz ? 32'hFFFF_FFFF : (neg_res ? (32'd0 - mplr) : mplr);
            hi <= neg_rem ? (32'd0 - rem) : rem;
          end else begin
            {hi, lo} <= neg_res ? (64'd0 - acc) : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: the directed table, randomized ops against an arithmetic
// reference model, and hand sequences for reset abort, MTHI/MTLO, and ignored starts.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we, sel_hi;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wdata;
  logic [31:0] result, hi, lo;
  logic        busy, done, div_by_zero;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .sel_hi(sel_hi),
    .result(result), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: returns {div_by_zero, hi, lo}, computed with plain arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0:    begin p = 64'(sa * sb); return {1'b0, p}; end
      2'd1:    begin p = ua * ub;      return {1'b0, p}; end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (o == 2'd2)  return {1'b0, 32'(sa % sb), 32'(sa / sb)};
        return {1'b0, 32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Expected number of edges from the start edge to the edge at which done rises.
  function automatic int exp_edges(input logic [1:0] o, input logic [31:0] b);
    logic [31:0] mag;
    int n;
    mag = (o == 2'd0 && b[31]) ? (32'd0 - b) : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    return (EARLY && !o[1]) ? n + 1 : 33;
  endfunction

  // Launch one op, scramble the operand inputs, wait for done, and check everything.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [64:0] exp, input string name);
    int edges, drops;
    @(negedge clk);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    sel_hi = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0; rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
    check({name, " busy"}, 64'(busy), 64'd1);
    edges = 0; drops = 0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (done !== 1'b1 && busy !== 1'b1) drops++;
    end
    check({name, " latency"}, 64'(edges), 64'(exp_edges(o, b)));
    check({name, " busy drops"}, 64'(drops), 64'd0);
    check({name, " hi:lo"}, {hi, lo}, exp[63:0]);
    check({name, " div_by_zero"}, 64'(div_by_zero), 64'(exp[64]));
    check({name, " result"}, 64'(result), 64'(sel_hi ? exp[63:32] : exp[31:0]));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs, rt, exp_hi, exp_lo;
    logic        exp_dz;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          edges, seen;
    logic [1:0]  o;
    logic [31:0] a, b;

    reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; sel_hi = 1'b0;
    op = 2'd0; rs_data = '0; rt_data = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset hi:lo", {hi, lo}, 64'd0);
    check("reset flags", {61'd0, busy, done, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    vecs.push_back('{2'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult -3*7"});
    vecs.push_back('{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu max*max"});
    vecs.push_back('{2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2"});
    vecs.push_back('{2'd3, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu 100/0"});
    vecs.push_back('{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div min/-1"});
    vecs.push_back('{2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div 7/-2"});
    vecs.push_back('{2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div -5/0"});
    vecs.push_back('{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult min*min"});
    vecs.push_back('{2'd1, 32'd5,         32'd1,         32'h0000_0000, 32'h0000_0005, 1'b0, "multu 5*1"});
    vecs.push_back('{2'd1, 32'd5,         32'h8000_0000, 32'h0000_0002, 32'h8000_0000, 1'b0, "multu 5*2^31"});
    vecs.push_back('{2'd0, 32'd0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0, "mult 0*-1"});
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt,
             {vecs[i].exp_dz, vecs[i].exp_hi, vecs[i].exp_lo}, vecs[i].name);

    // Randomized operations issued back-to-back; each start lands in the done cycle.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'd1 << $urandom_range(0, 31);
        3:       b = 32'd0 - 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(o, a, b, model(o, a, b), "rand");
    end

    // Reset at edge 10 of a MULT aborts the op, and no done follows.
    @(negedge clk);
    op = 2'd0; rs_data = 32'd3; rt_data = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(posedge clk);
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'd0);
    check("abort hi:lo", {hi, lo}, 64'd0);
    check("abort done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort no done", 64'(seen), 64'd0);

    // MTHI, then MTLO with a same-cycle read through result.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we = 1'b0; sel_hi = 1'b1;
    #1;
    check("mthi result", 64'(result), 64'h1234_5678);
    @(negedge clk);
    lo_we = 1'b1; wdata = 32'h0000_55AA;
    @(posedge clk); #1;
    lo_we = 1'b0; sel_hi = 1'b0;
    #1;
    check("mtlo result", 64'(result), 64'h0000_55AA);

    // DIVU started together with an MTLO, which is dropped. A second start
    // and an MTHI arriving while busy are both ignored.
    @(negedge clk);
    op = 2'd3; rs_data = 32'd1000; rt_data = 32'd7; start = 1'b1;
    lo_we = 1'b1; wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0; sel_hi = 1'b1;
    check("start beats mtlo", 64'(lo), 64'h0000_55AA);
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      if (edges == 4) begin
        start = 1'b1; op = 2'd0; rs_data = 32'd9; rt_data = 32'd9;
        hi_we = 1'b1; wdata = 32'h0000_DEAD;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (edges == 6) check("hi held while busy", 64'(result), 64'h1234_5678);
    end
    start = 1'b0; hi_we = 1'b0;
    check("divu latency", 64'(edges), 64'd33);
    check("divu hi:lo", {hi, lo}, {32'd6, 32'd142});
    @(posedge clk); #1;
    check("done one cycle", 64'(done), 64'd0);
    check("second start ignored", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
